alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Registered, parametrised ALU for the multicycle CPU datapath; successor to the combinational ALU.
- Keeps the existing 4-bit op encoding and adds XOR, signed SLT, shifts and an iterative unsigned multiply (shift-add, one bit per cycle).
- Uses a start/busy/done handshake, so the control FSM waits on done instead of a fixed stage count.
- Results and the zero flag are registered and held until the next completed operation.

Parameters:
- WIDTH, 32, operand/result width; must be a power of two, >= 4.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; samples operands and op this cycle when idle.
- ALU_selection  in  4  operation code.
- ALU_in_A  in  WIDTH  operand A.
- ALU_in_B  in  WIDTH  operand B (may carry an immediate).
- ALUoutput  out  WIDTH  result, or low product half for MUL.
- ALUoutput_hi  out  WIDTH  high product half for MUL; 0 for all other ops.
- Beq_alu  out  1  1 when the registered ALUoutput == 0 (all ops).
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when results become valid.
- op_err  out  1  registered with done; 1 for an undefined op code.

Behaviour:
- Reset (synchronous, active-high, clk/rst as named): all outputs 0, FSM to IDLE. Reset mid-MUL aborts with no done pulse.
- FSM states: IDLE, EXEC, MUL, DONE.
- IDLE, start=1: latch A, B and op. MUL op (1101) goes to MUL with cnt=0; any other op goes to EXEC.
- EXEC: compute and register results; go to DONE.
- MUL:
  - each cycle, if mplier[0], acc += mcand (2*WIDTH-bit acc); mcand <<= 1; mplier >>= 1; cnt++.
  - after WIDTH iterations, go to DONE.
- DONE: done=1 for exactly one cycle; return to IDLE. start in this cycle is ignored.
- busy=1 in EXEC, MUL and DONE. start while busy is ignored; operands are not re-sampled.
- Latency from the start edge to the done cycle:
  - single-cycle ops: 2 clocks.
  - MUL: WIDTH+2 clocks.
  - a new start is accepted on the cycle after done.
- Op codes:
  - 0000 A; 0001 ~A; 0010 A+B (mod 2^WIDTH, carry dropped); 0011 A-B (mod 2^WIDTH).
  - 0100 A|B; 0101 A&B; 0110 A^B.
  - 0111 unsigned A<B ? 1 : 0; 1000 signed A<B ? 1 : 0.
  - 1001 B.
  - 1010 A<<B[SHW-1:0]; 1011 logical A>>B[SHW-1:0]; 1100 arithmetic A>>>B[SHW-1:0]. Upper B bits are ignored.
  - 1101 MUL unsigned: {ALUoutput_hi, ALUoutput} = A*B.
  - 1110, 1111 undefined: ALUoutput=0, ALUoutput_hi=0, op_err=1, Beq_alu=1.
- Output timing: ALUoutput, ALUoutput_hi, Beq_alu and op_err update only on the cycle done rises, and hold until the next done or reset. op_err is cleared by the next legal op.
- Inputs may change freely after start is accepted; the result depends only on the latched values.
- MUL edge cases: B=0 or A=0 gives 0 after the full WIDTH cycles (no early exit). Latency is fixed and data-independent.

Test Plan:
- Reset, then add: WIDTH=32, A=0xFFFFFFFF, B=1, op 0010 -> done 2 clocks after start; ALUoutput=0, Beq_alu=1, ALUoutput_hi=0, op_err=0.
- SLT signed vs unsigned: A=0xFFFFFFFE, B=2 -> op 0111 gives 0; op 1000 gives 1.
- Shift amount masking: A=0x80000000, B=0x21 -> op 1100 gives 0xC0000000; op 1011 gives 0x40000000; op 1010 with A=1 gives 2.
- MUL with input change: A=0xFFFFFFFF, B=0xFFFFFFFF, op 1101, then drive A=B=0 while busy -> done exactly 34 clocks after the start edge; hi=0xFFFFFFFE, lo=0x00000001; busy high throughout. A start issued mid-MUL is ignored.
- Reset mid-MUL: start MUL, assert rst at cycle 10 -> no done pulse; all outputs 0 the next cycle. A subsequent op 0000 with A=5 completes normally with ALUoutput=5.
- Illegal op then recovery: op 1111 -> op_err=1, ALUoutput=0, Beq_alu=1. Next op 1001 with B=7 -> op_err=0, ALUoutput=7, Beq_alu=0.

Source files
------------

// File: rtl/alu_seq.sv
// Registered multicycle ALU: single-cycle ops go through EXEC, unsigned multiply
// iterates one multiplier bit per cycle in MUL. Results are held until the next done.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALU_selection,
  input  logic [WIDTH-1:0] ALU_in_A,
  input  logic [WIDTH-1:0] ALU_in_B,
  output logic [WIDTH-1:0] ALUoutput,
  output logic [WIDTH-1:0] ALUoutput_hi,
  output logic             Beq_alu,
  output logic             busy,
  output logic             done,
  output logic             op_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0]   OP_MUL   = 4'b1101;
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SHW:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_lo_q, out_lo_d;
  logic [WIDTH-1:0]   out_hi_q, out_hi_d;
  logic               beq_q, beq_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   exec_res;
  logic               exec_err;
  logic [SHW-1:0]     shamt;

  assign shamt = b_q[SHW-1:0];

  always_comb begin
    exec_res = '0;
    exec_err = 1'b0;
    case (op_q)
      4'b0000: exec_res = a_q;
      4'b0001: exec_res = ~a_q;
      4'b0010: exec_res = a_q + b_q;
      4'b0011: exec_res = a_q - b_q;
      4'b0100: exec_res = a_q | b_q;
      4'b0101: exec_res = a_q & b_q;
      4'b0110: exec_res = a_q ^ b_q;
      4'b0111: exec_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      4'b1000: exec_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      4'b1001: exec_res = b_q;
      4'b1010: exec_res = a_q << shamt;
      4'b1011: exec_res = a_q >> shamt;
      4'b1100: exec_res = $signed(a_q) >>> shamt;
      default: exec_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    beq_d    = beq_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = ALU_selection;
          a_d     = ALU_in_A;
          b_d     = ALU_in_B;
          mcand_d = {{WIDTH{1'b0}}, ALU_in_A};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (ALU_selection == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        out_lo_d = exec_res;
        out_hi_d = '0;
        err_d    = exec_err;
        beq_d    = (exec_res == '0);
        state_d  = DONE;
      end
      MUL: begin
        // b_q doubles as the multiplier shift register; the finishing cycle only publishes.
        if (cnt_q == CNT_LAST) begin
          out_lo_d = acc_q[WIDTH-1:0];
          out_hi_d = acc_q[2*WIDTH-1:WIDTH];
          err_d    = 1'b0;
          beq_d    = (acc_q[WIDTH-1:0] == '0);
          state_d  = DONE;
        end else begin
          acc_d   = acc_q + (b_q[0] ? mcand_q : '0);
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_lo_q <= '0;
      out_hi_q <= '0;
      beq_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
      beq_q    <= beq_d;
      err_q    <= err_d;
    end
  end

  assign ALUoutput    = out_lo_q;
  assign ALUoutput_hi = out_hi_q;
  assign Beq_alu      = beq_q;
  assign op_err       = err_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: vector table plus random ops through a scoreboard queue,
// and hand-written sequences for mid-MUL restart attempts and reset.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  sel;
  logic [31:0] a_in, b_in;
  logic [31:0] alu_out, alu_out_hi;
  logic        beq, busy, done, op_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, lo, hi;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] lo, hi;
    logic        beq, err;
    int          lat, start_cyc;
  } exp_t;

  exp_t exp_q[$];

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ALU_selection(sel),
    .ALU_in_A(a_in), .ALU_in_B(b_in), .ALUoutput(alu_out),
    .ALUoutput_hi(alu_out_hi), .Beq_alu(beq), .busy(busy),
    .done(done), .op_err(op_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Independent reference: full 64-bit product, language shift operators.
  function automatic logic [64:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    r = '0;
    p = 64'(a) * 64'(b);
    case (op)
      4'h0: r = a;
      4'h1: r = ~a;
      4'h2: r = a + b;
      4'h3: r = a - b;
      4'h4: r = a | b;
      4'h5: r = a & b;
      4'h6: r = a ^ b;
      4'h7: r = (a < b) ? 32'd1 : 32'd0;
      4'h8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h9: r = b;
      4'hA: r = a << b[4:0];
      4'hB: r = a >> b[4:0];
      4'hC: r = 32'($signed(a) >>> b[4:0]);
      4'hD: return {1'b0, p};
      default: return {1'b1, 64'd0};
    endcase
    return {1'b0, 32'd0, r};
  endfunction

  // Scoreboard: every done pops one expectation; a done with nothing queued is an error.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("lo", 64'(alu_out), 64'(e.lo));
        check_output("hi", 64'(alu_out_hi), 64'(e.hi));
        check_output("beq", 64'(beq), 64'(e.beq));
        check_output("op_err", 64'(op_err), 64'(e.err));
        check_output("latency", 64'(cyc - e.start_cyc + 1), 64'(e.lat));
      end
    end
  end

  // Called just after a negedge with the DUT idle; start is seen on the next posedge.
  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] lo,
                                input logic [31:0] hi, input logic err);
    exp_t e;
    sel   = op;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.lo = lo; e.hi = hi; e.err = err; e.beq = (lo == 32'd0);
    e.lat = (op == 4'hD) ? 34 : 2;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    sel  = 4'($urandom);
    a_in = $urandom;
    b_in = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    check_output("timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
  endtask

  vec_t vecs[18];

  initial begin
    logic [64:0] m;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    logic        busy_ok;
    logic        got;

    vecs[0]  = '{4'h2, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0, 1'b0};
    vecs[1]  = '{4'h7, 32'hFFFFFFFE, 32'h2,        32'h0,        32'h0, 1'b0};
    vecs[2]  = '{4'h8, 32'hFFFFFFFE, 32'h2,        32'h1,        32'h0, 1'b0};
    vecs[3]  = '{4'hC, 32'h80000000, 32'h21,       32'hC0000000, 32'h0, 1'b0};
    vecs[4]  = '{4'hB, 32'h80000000, 32'h21,       32'h40000000, 32'h0, 1'b0};
    vecs[5]  = '{4'hA, 32'h1,        32'h21,       32'h2,        32'h0, 1'b0};
    vecs[6]  = '{4'hF, 32'h12345678, 32'h9,        32'h0,        32'h0, 1'b1};
    vecs[7]  = '{4'h9, 32'h0,        32'h7,        32'h7,        32'h0, 1'b0};
    vecs[8]  = '{4'h0, 32'h5,        32'h0,        32'h5,        32'h0, 1'b0};
    vecs[9]  = '{4'h1, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0, 1'b0};
    vecs[10] = '{4'h3, 32'h3,        32'h5,        32'hFFFFFFFE, 32'h0, 1'b0};
    vecs[11] = '{4'h4, 32'hF0,       32'h0F,       32'hFF,       32'h0, 1'b0};
    vecs[12] = '{4'h5, 32'hF0,       32'h3C,       32'h30,       32'h0, 1'b0};
    vecs[13] = '{4'h6, 32'hFF,       32'h0F,       32'hF0,       32'h0, 1'b0};
    vecs[14] = '{4'hD, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h0, 1'b0};
    vecs[15] = '{4'hD, 32'h10000,    32'h10000,    32'h0,        32'h1, 1'b0};
    vecs[16] = '{4'hE, 32'h1,        32'h1,        32'h0,        32'h0, 1'b1};
    vecs[17] = '{4'hD, 32'h7,        32'h6,        32'h2A,       32'h0, 1'b0};

    rst = 1'b1; start = 1'b0; sel = 4'h0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check_output("rst_lo", 64'(alu_out), 64'd0);
    check_output("rst_hi", 64'(alu_out_hi), 64'd0);
    check_output("rst_beq", 64'(beq), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(done), 64'd0);
    check_output("rst_err", 64'(op_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].err);
      wait_done();
    end

    for (int i = 0; i < 20; i++) begin
      rop = 4'($urandom);
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      m   = model(rop, ra, rb);
      apply_stimulus(rop, ra, rb, m[31:0], m[63:32], m[64]);
      wait_done();
    end

    // MUL with operands cleared and a stray start while busy.
    apply_stimulus(4'hD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0);
    a_in = '0; b_in = '0;
    busy_ok = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      if (i == 10) begin
        start = 1'b1; sel = 4'h0; a_in = 32'h5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check_output("mul_busy_throughout", 64'(busy_ok), 64'd1);
    check_output("mul_done_seen", 64'(got), 64'd1);
    repeat (40) @(negedge clk);
    check_output("mul_idle_after", 64'(busy), 64'd0);

    // Reset in the middle of a multiply.
    sel = 4'hD; a_in = 32'h3; b_in = 32'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check_output("mid_mul_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("mid_rst_lo", 64'(alu_out), 64'd0);
    check_output("mid_rst_hi", 64'(alu_out_hi), 64'd0);
    check_output("mid_rst_busy", 64'(busy), 64'd0);
    check_output("mid_rst_done", 64'(done), 64'd0);
    repeat (40) @(negedge clk);
    apply_stimulus(4'h0, 32'h5, 32'h0, 32'h5, 32'h0, 1'b0);
    wait_done();

    // Illegal op then recovery.
    apply_stimulus(4'hF, 32'hABCD, 32'h1, 32'h0, 32'h0, 1'b1);
    wait_done();
    apply_stimulus(4'h9, 32'h0, 32'h7, 32'h7, 32'h0, 1'b0);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
